alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Sequences one logic operation at a time through an external,
//   purely combinational 4-bit ALU. An accepted command is registered
//   onto the ALU operand/select lines. The sequencer waits SETTLE_CYC
//   clock edges, captures the ALU result, and then holds it on the
//   response port until the consumer takes it.
//
// Parameters:
//   SETTLE_CYC  Edges between driving the ALU operands and sampling
//               alu_out. The legal range is 1..15.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (high in IDLE only)
//   cmd_a/b    4-bit operands
//   cmd_op     00 AND, 01 OR, 10 XOR, 11 XNOR
//   alu_in1/2  operands driven to the external ALU
//   alu_sel    operation select driven to the external ALU
//   alu_out    combinational result from the external ALU
//   rsp_valid  captured result available
//   rsp_ready  consumer accepts the result
//   rsp_data   captured result
//   rsp_op     op code belonging to rsp_data
//   busy       high whenever the FSM is not in IDLE
//
// Optional feature (macro ALU_SEQ_CHECK_EN):
//   chk_err    one-cycle pulse, aligned with the first rsp_valid cycle,
//              when alu_out disagrees with the locally computed result
//   err_cnt    saturating (255) count of such disagreements
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [1:0] rsp_op,
    output logic       busy
`ifdef ALU_SEQ_CHECK_EN
    ,
    output logic       chk_err,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_reg;
    logic       cmd_ready_reg;
    logic       busy_reg;
    logic [3:0] cnt_reg;
    logic [3:0] alu_in1_reg;
    logic [3:0] alu_in2_reg;
    logic [1:0] alu_sel_reg;
    logic       rsp_valid_reg;
    logic [3:0] rsp_data_reg;
    logic [1:0] rsp_op_reg;

`ifdef ALU_SEQ_CHECK_EN
    logic       chk_err_reg;
    logic [7:0] err_cnt_reg;
    logic [3:0] expected_next;
    logic       mismatch_next;

    // Reference result from the operands the sequencer itself is driving,
    // so a faulty ALU cannot mask its own error.
    always_comb begin
        expected_next = 4'h0;
        unique case (alu_sel_reg)
            2'b00: expected_next = alu_in1_reg & alu_in2_reg;
            2'b01: expected_next = alu_in1_reg | alu_in2_reg;
            2'b10: expected_next = alu_in1_reg ^ alu_in2_reg;
            2'b11: expected_next = ~(alu_in1_reg ^ alu_in2_reg);
            default: expected_next = 4'h0;
        endcase
        mismatch_next = (alu_out != expected_next);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            cnt_reg       <= 4'd0;
            alu_in1_reg   <= 4'h0;
            alu_in2_reg   <= 4'h0;
            alu_sel_reg   <= 2'b00;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 4'h0;
            rsp_op_reg    <= 2'b00;
`ifdef ALU_SEQ_CHECK_EN
            chk_err_reg   <= 1'b0;
            err_cnt_reg   <= 8'd0;
`endif
        end else begin
`ifdef ALU_SEQ_CHECK_EN
            // chk_err is a single-cycle pulse; only the capture edge raises it.
            chk_err_reg <= 1'b0;
`endif
            unique case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        alu_in1_reg   <= cmd_a;
                        alu_in2_reg   <= cmd_b;
                        alu_sel_reg   <= cmd_op;
                        cnt_reg       <= SETTLE_LD;
                        state_reg     <= ST_WAIT;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    // Counter reaches zero on this edge: the ALU has had
                    // SETTLE_CYC cycles to settle, so sample it now.
                    if (cnt_reg == 4'd1) begin
                        rsp_data_reg  <= alu_out;
                        rsp_op_reg    <= alu_sel_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
`ifdef ALU_SEQ_CHECK_EN
                        if (mismatch_next) begin
                            chk_err_reg <= 1'b1;
                            if (err_cnt_reg != 8'hFF) begin
                                err_cnt_reg <= err_cnt_reg + 8'd1;
                            end
                        end
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign busy      = busy_reg;
    assign alu_in1   = alu_in1_reg;
    assign alu_in2   = alu_in2_reg;
    assign alu_sel   = alu_sel_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_op    = rsp_op_reg;
`ifdef ALU_SEQ_CHECK_EN
    assign chk_err   = chk_err_reg;
    assign err_cnt   = err_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Two sequencer instances: index 0 with SETTLE_CYC=1, index 1 with
// SETTLE_CYC=3. Each has a behavioural external ALU. Expected responses
// are pushed into a per-instance scoreboard when a command is accepted.
// A monitor process pops and compares them whenever a response appears.
// Honours ALU_SEQ_CHECK_EN for the optional checker outputs.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int SET0 = 1;
    localparam int SET1 = 3;
    localparam int TMO  = 100;

    typedef struct {
        logic [3:0] data;
        logic [1:0] op;
        int         acc;
        bit         bad;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [3:0] cmd_a     [2];
    logic [3:0] cmd_b     [2];
    logic [1:0] cmd_op    [2];
    logic [3:0] alu_in1   [2];
    logic [3:0] alu_in2   [2];
    logic [1:0] alu_sel   [2];
    logic [3:0] alu_out   [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [3:0] rsp_data  [2];
    logic [1:0] rsp_op    [2];
    logic       busy      [2];
`ifdef ALU_SEQ_CHECK_EN
    logic       chk_err   [2];
    logic [7:0] err_cnt   [2];
    int         exp_err   [2];
`endif

    bit         fixed_rdy [2];
    bit         rand_mode [2];
    logic [1:0] rnd_rdy;
    bit         force_zero;
    logic       rst_seen;
    int         cyc;

    exp_t       sb [2][256];
    int         wp [2];
    int         rp [2];
    bit         prev_v   [2];
    bit         prev_rdy [2];
    logic [3:0] prev_d   [2];
    logic [1:0] prev_op  [2];

    int checks;
    int failures;

    // Reference ALU behaviour: plain operator table.
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? SET0 : SET1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            alu_op_sequencer #(.SETTLE_CYC((gi == 0) ? SET0 : SET1)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .cmd_valid (cmd_valid[gi]),
                .cmd_ready (cmd_ready[gi]),
                .cmd_a     (cmd_a[gi]),
                .cmd_b     (cmd_b[gi]),
                .cmd_op    (cmd_op[gi]),
                .alu_in1   (alu_in1[gi]),
                .alu_in2   (alu_in2[gi]),
                .alu_sel   (alu_sel[gi]),
                .alu_out   (alu_out[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready[gi]),
                .rsp_data  (rsp_data[gi]),
                .rsp_op    (rsp_op[gi]),
                .busy      (busy[gi])
`ifdef ALU_SEQ_CHECK_EN
                ,
                .chk_err   (chk_err[gi]),
                .err_cnt   (err_cnt[gi])
`endif
            );
            assign alu_out[gi]   = force_zero ? 4'h0 : alu_f(alu_in1[gi], alu_in2[gi], alu_sel[gi]);
            assign rsp_ready[gi] = rand_mode[gi] ? rnd_rdy[gi] : fixed_rdy[gi];
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        rnd_rdy  <= 2'($urandom_range(0, 3));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One monitor step per instance, run on every falling edge.
    task automatic mon_step(input int i);
        exp_t e;
        if (rst_seen) begin
            rp[i]      = wp[i];   // abandoned operations produce nothing
            prev_v[i]  = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
            exp_err[i] = 0;
`endif
            return;
        end
        if (rsp_valid[i] && !prev_v[i]) begin
            if (rp[i] == wp[i]) begin
                chk($sformatf("dut%0d_unexpected_rsp", i), 32'(rsp_valid[i]), 32'd0);
            end else begin
                e = sb[i][rp[i] & 255];
                rp[i]++;
                chk($sformatf("dut%0d_rsp_data", i), 32'(rsp_data[i]), 32'(e.data));
                chk($sformatf("dut%0d_rsp_op", i), 32'(rsp_op[i]), 32'(e.op));
                chk($sformatf("dut%0d_rsp_latency", i), 32'(cyc), 32'(e.acc + settle_of(i)));
`ifdef ALU_SEQ_CHECK_EN
                if (e.bad && exp_err[i] < 255) exp_err[i]++;
                chk($sformatf("dut%0d_chk_err", i), 32'(chk_err[i]), 32'(e.bad));
                chk($sformatf("dut%0d_err_cnt", i), 32'(err_cnt[i]), 32'(exp_err[i]));
`endif
                $display("dut%0d rsp data=%h op=%0d accepted@%0d seen@%0d",
                         i, rsp_data[i], rsp_op[i], e.acc, cyc);
            end
        end else if (prev_v[i]) begin
            if (!prev_rdy[i]) begin
                chk($sformatf("dut%0d_hold_valid", i), 32'(rsp_valid[i]), 32'd1);
                chk($sformatf("dut%0d_hold_data", i), 32'(rsp_data[i]), 32'(prev_d[i]));
                chk($sformatf("dut%0d_hold_op", i), 32'(rsp_op[i]), 32'(prev_op[i]));
            end else begin
                chk($sformatf("dut%0d_valid_clear", i), 32'(rsp_valid[i]), 32'd0);
            end
`ifdef ALU_SEQ_CHECK_EN
            chk($sformatf("dut%0d_chk_err_width", i), 32'(chk_err[i]), 32'd0);
`endif
        end
        prev_v[i]   = rsp_valid[i];
        prev_rdy[i] = rsp_ready[i];
        prev_d[i]   = rsp_data[i];
        prev_op[i]  = rsp_op[i];
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    endtask

    // Offer a command and hold it until accepted; acc = acceptance edge index.
    task automatic send(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        cmd_a[i]     = a;
        cmd_b[i]     = b;
        cmd_op[i]    = op;
        cmd_valid[i] = 1'b1;
        n = 0;
        while (!cmd_ready[i] && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready[i]) begin
            chk($sformatf("dut%0d_cmd_ready_timeout", i), 32'(cmd_ready[i]), 32'd1);
            cmd_valid[i] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc    = cyc;
        e.data = force_zero ? 4'h0 : alu_f(a, b, op);
        e.op   = op;
        e.acc  = acc;
        e.bad  = force_zero && (alu_f(a, b, op) != 4'h0);
        sb[i][wp[i] & 255] = e;
        wp[i]++;
        cmd_valid[i] = 1'b0;
        chk($sformatf("dut%0d_alu_in1", i), 32'(alu_in1[i]), 32'(a));
        chk($sformatf("dut%0d_alu_in2", i), 32'(alu_in2[i]), 32'(b));
        chk($sformatf("dut%0d_alu_sel", i), 32'(alu_sel[i]), 32'(op));
        chk($sformatf("dut%0d_ready_low", i), 32'(cmd_ready[i]), 32'd0);
        chk($sformatf("dut%0d_busy", i), 32'(busy[i]), 32'd1);
    endtask

    task automatic reset_check(input int i);
        chk($sformatf("dut%0d_rst_cmd_ready", i), 32'(cmd_ready[i]), 32'd1);
        chk($sformatf("dut%0d_rst_busy", i), 32'(busy[i]), 32'd0);
        chk($sformatf("dut%0d_rst_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
        chk($sformatf("dut%0d_rst_rsp_data", i), 32'(rsp_data[i]), 32'd0);
        chk($sformatf("dut%0d_rst_rsp_op", i), 32'(rsp_op[i]), 32'd0);
        chk($sformatf("dut%0d_rst_alu_in1", i), 32'(alu_in1[i]), 32'd0);
        chk($sformatf("dut%0d_rst_alu_in2", i), 32'(alu_in2[i]), 32'd0);
        chk($sformatf("dut%0d_rst_alu_sel", i), 32'(alu_sel[i]), 32'd0);
`ifdef ALU_SEQ_CHECK_EN
        chk($sformatf("dut%0d_rst_chk_err", i), 32'(chk_err[i]), 32'd0);
        chk($sformatf("dut%0d_rst_err_cnt", i), 32'(err_cnt[i]), 32'd0);
`endif
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!(cmd_ready[i] && !rsp_valid[i]) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!(cmd_ready[i] && !rsp_valid[i]))
            chk($sformatf("dut%0d_idle_timeout", i), 32'(cmd_ready[i]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int acc2;
        int prev_acc;
        int h;
        int n;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        force_zero = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_a[i]     = 4'h0;
            cmd_b[i]     = 4'h0;
            cmd_op[i]    = 2'b00;
            fixed_rdy[i] = 1'b1;
            rand_mode[i] = 1'b0;
            wp[i]        = 0;
            rp[i]        = 0;
            prev_v[i]    = 1'b0;
            prev_rdy[i]  = 1'b0;
            prev_d[i]    = 4'h0;
            prev_op[i]   = 2'b00;
`ifdef ALU_SEQ_CHECK_EN
            exp_err[i]   = 0;
`endif
        end
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset_check(0);
        reset_check(1);
        rst = 1'b0;

        // Directed operations, SETTLE_CYC=1
        send(0, 4'hC, 4'hA, 2'b00, acc);
        send(0, 4'h5, 4'h3, 2'b11, acc);
        send(0, 4'h5, 4'h3, 2'b10, acc);

        // Response back-pressure while a second command is offered
        wait_idle(0);
        fixed_rdy[0] = 1'b0;
        send(0, 4'h9, 4'h6, 2'b01, acc);
        h = 0;
        fork
            send(0, 4'h7, 4'hE, 2'b00, acc2);
            begin
                n = 0;
                @(negedge clk);
                while (!rsp_valid[0] && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) begin
                    @(negedge clk);
                    chk("dut0_hold_cmd_ready", 32'(cmd_ready[0]), 32'd0);
                    chk("dut0_hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
                end
                @(posedge clk);
                #1;
                fixed_rdy[0] = 1'b1;
                @(posedge clk);
                #1;
                h = cyc;
            end
        join
        chk("dut0_second_accept_edge", 32'(acc2), 32'(h + 1));

        // Back-to-back, SETTLE_CYC=3, rsp_ready high
        wait_idle(1);
        prev_acc = 0;
        for (int k = 0; k < 12; k++) begin
            send(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), acc);
            if (k > 0) chk("dut1_accept_spacing", 32'(acc), 32'(prev_acc + SET1 + 2));
            prev_acc = acc;
        end

        // Random operands, random back-pressure, random idle gaps
        rand_mode[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_mode[1] = 1'b0;
        wait_idle(1);

`ifdef ALU_SEQ_CHECK_EN
        // Faulty ALU stub: every 1|2 command should be flagged
        wait_idle(0);
        force_zero = 1'b1;
        for (int k = 0; k < 300; k++) send(0, 4'h1, 4'h2, 2'b01, acc);
        wait_idle(0);
        chk("dut0_err_cnt_saturated", 32'(err_cnt[0]), 32'd255);
        force_zero = 1'b0;
        send(0, 4'h1, 4'h2, 2'b01, acc);
        wait_idle(0);
`endif

        // Reset while in WAIT, SETTLE_CYC=3: abandoned, no response
        send(1, 4'hF, 4'h3, 2'b10, acc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        reset_check(0);
        reset_check(1);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("dut1_no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
        end

        // Recovery after reset
        send(1, 4'hA, 4'h5, 2'b11, acc);
        send(0, 4'h3, 4'h6, 2'b00, acc);
        repeat (10) @(posedge clk);
        #1;
        chk("dut0_scoreboard_drained", 32'(rp[0]), 32'(wp[0]));
        chk("dut1_scoreboard_drained", 32'(rp[1]), 32'(wp[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
